// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sequencer.
package tt_pkg;

   // Sweep controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tt_state_t;

   // Default width of the function-under-test input vector
   localparam int N_IN_DEFAULT = 2;

   // Number of truth-table rows for an n-input function
   function automatic int rows(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-window down-counter: loads SETTLE, counts down to zero and holds there.
// zero_o is high whenever the count is zero, so SETTLE=0 samples on the apply cycle.
module tt_settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int TW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   assign zero_o = (count_q == '0);

   // Next count: load wins over decrement; never decrement past zero
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = LOAD_VAL;
      end else if (dec_i && !zero_o) begin
         count_d = count_q - TW'(1);
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sweep of an N_IN-input, single-output function.
// Applies vectors 0..ROWS-1, holds each for SETTLE+1 cycles, samples the output on
// the last hold cycle, and compares the captured table with a latched expected table.
// Optional build macro FIRST_FAIL_CAPTURE_EN adds first_fail_idx / fail_seen outputs
// recording the first mismatching row of each sweep.
module truth_table_sequencer
   import tt_pkg::*;
#(
   parameter int N_IN   = N_IN_DEFAULT,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [rows(N_IN)-1:0] expected,
   output logic [N_IN-1:0]      dut_in,
   input  logic                 dut_out,
   output logic                 busy,
   output logic                 done,
   output logic [rows(N_IN)-1:0] table_out,
   output logic [N_IN:0]        mismatch_cnt,
   output logic                 pass
`ifdef FIRST_FAIL_CAPTURE_EN
   ,
   output logic [N_IN-1:0]      first_fail_idx,
   output logic                 fail_seen
`endif
);

   localparam int ROWS = rows(N_IN);
   localparam logic [N_IN-1:0] LAST_IDX = N_IN'(ROWS - 1);

   tt_state_t         state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [ROWS-1:0]   exp_q, exp_d;
   logic [ROWS-1:0]   table_q, table_d;
   logic [N_IN:0]     cnt_q, cnt_d;
   logic              pass_q, pass_d;
   logic              timer_load;
   logic              timer_dec;
   logic              timer_zero;
   logic              row_mis;
`ifdef FIRST_FAIL_CAPTURE_EN
   logic [N_IN-1:0]   ffi_q, ffi_d;
   logic              fseen_q, fseen_d;
`endif

   tt_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load_i (timer_load),
      .dec_i  (timer_dec),
      .zero_o (timer_zero)
   );

   // The row under test mismatches when the sampled output differs from the latched copy
   assign row_mis = dut_out ^ exp_q[idx_q];

   // Next-state and datapath updates for the sweep FSM
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      exp_d      = exp_q;
      table_d    = table_q;
      cnt_d      = cnt_q;
      pass_d     = pass_q;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ffi_d      = ffi_q;
      fseen_d    = fseen_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d      = expected;
               table_d    = '0;
               cnt_d      = '0;
               pass_d     = 1'b0;
               idx_d      = '0;
               timer_load = 1'b1;
               state_d    = RUN;
`ifdef FIRST_FAIL_CAPTURE_EN
               ffi_d      = '0;
               fseen_d    = 1'b0;
`endif
            end
         end
         RUN: begin
            if (!timer_zero) begin
               timer_dec = 1'b1;
            end else begin
               table_d[idx_q] = dut_out;
               cnt_d          = cnt_q + (N_IN + 1)'(row_mis);
`ifdef FIRST_FAIL_CAPTURE_EN
               if (row_mis && !fseen_q) begin
                  fseen_d = 1'b1;
                  ffi_d   = idx_q;
               end
`endif
               if (idx_q == LAST_IDX) begin
                  pass_d  = (cnt_d == '0);
                  state_d = DONE;
               end else begin
                  idx_d      = idx_q + N_IN'(1);
                  timer_load = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous active-high reset clears everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         exp_q   <= '0;
         table_q <= '0;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
         ffi_q   <= '0;
         fseen_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exp_q   <= exp_d;
         table_q <= table_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
`ifdef FIRST_FAIL_CAPTURE_EN
         ffi_q   <= ffi_d;
         fseen_q <= fseen_d;
`endif
      end
   end

   // dut_in is the row index itself, so it holds the last row after a sweep
   assign dut_in       = idx_q;
   assign busy         = (state_q == RUN);
   assign done         = (state_q == DONE);
   assign table_out    = table_q;
   assign mismatch_cnt = cnt_q;
   assign pass         = pass_q;
`ifdef FIRST_FAIL_CAPTURE_EN
   assign first_fail_idx = ffi_q;
   assign fail_seen      = fseen_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: a 2-input/SETTLE=1 instance driving
// s = ~x & y, and a 3-input/SETTLE=0 instance driving 3-bit parity.
module tb_truth_table_sequencer;
   import tt_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] expected;
   logic [1:0] dut_in;
   logic       dut_out;
   logic       busy;
   logic       done;
   logic [3:0] table_out;
   logic [2:0] mismatch_cnt;
   logic       pass;

   logic       start3;
   logic [7:0] expected3;
   logic [2:0] dut_in3;
   logic       dut_out3;
   logic       busy3;
   logic       done3;
   logic [7:0] table_out3;
   logic [3:0] mismatch_cnt3;
   logic       pass3;
`ifdef FIRST_FAIL_CAPTURE_EN
   logic [1:0] first_fail_idx;
   logic       fail_seen;
   logic [2:0] first_fail_idx3;
   logic       fail_seen3;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Functions under test: s = ~x & y with x = dut_in[1], y = dut_in[0]; and parity
   assign dut_out  = ~dut_in[1] & dut_in[0];
   assign dut_out3 = ^dut_in3;

   truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .expected     (expected),
      .dut_in       (dut_in),
      .dut_out      (dut_out),
      .busy         (busy),
      .done         (done),
      .table_out    (table_out),
      .mismatch_cnt (mismatch_cnt),
      .pass         (pass)
`ifdef FIRST_FAIL_CAPTURE_EN
      ,
      .first_fail_idx (first_fail_idx),
      .fail_seen      (fail_seen)
`endif
   );

   truth_table_sequencer #(.N_IN(3), .SETTLE(0)) u_dut3 (
      .clk          (clk),
      .reset        (reset),
      .start        (start3),
      .expected     (expected3),
      .dut_in       (dut_in3),
      .dut_out      (dut_out3),
      .busy         (busy3),
      .done         (done3),
      .table_out    (table_out3),
      .mismatch_cnt (mismatch_cnt3),
      .pass         (pass3)
`ifdef FIRST_FAIL_CAPTURE_EN
      ,
      .first_fail_idx (first_fail_idx3),
      .fail_seen      (fail_seen3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted start on the 2-input instance; returns the cycle in which done rose
   task automatic sweep2(input logic [3:0] e, output int lat);
      expected = e;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      lat      = 1;
      while (!done && lat < 60) begin
         tick();
         lat++;
      end
      $display("sweep2 exp=%b done_cycle=%0d table=%b mism=%0d pass=%0b",
               e, lat, table_out, mismatch_cnt, pass);
   endtask

   initial begin
      int lat;
      int done_seen;
      logic [15:0] seq;

      reset     = 1'b1;
      start     = 1'b0;
      start3    = 1'b0;
      expected  = 4'b0000;
      expected3 = 8'h00;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state of both instances
      chk("rst_outs", {dut_in, busy, done, table_out, mismatch_cnt, pass}, 32'd0);
      chk("rst_outs3", {dut_in3, busy3, done3, table_out3, mismatch_cnt3, pass3}, 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
      chk("rst_ffc", {first_fail_idx, fail_seen}, 32'd0);
`endif
      $display("reset checked");

      // Case 1: matching table, done in cycle 9
      expected = 4'b0010;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk("c1_busy_c1", busy, 1'b1);
      chk("c1_dutin_c1", dut_in, 2'd0);
      lat = 1;
      while (!done && lat < 60) begin
         tick();
         lat++;
      end
      $display("case1 done_cycle=%0d table=%b mism=%0d pass=%0b", lat, table_out, mismatch_cnt, pass);
      chk("c1_latency", lat, 32'd9);
      chk("c1_table", table_out, 4'b0010);
      chk("c1_mism", mismatch_cnt, 3'd0);
      chk("c1_pass", pass, 1'b1);
      chk("c1_busy_done", busy, 1'b0);
      tick();
      chk("c1_done_pulse", done, 1'b0);
      chk("c1_retain", {table_out, mismatch_cnt, pass, dut_in}, {4'b0010, 3'd0, 1'b1, 2'd3});

      // Case 2: expected 1000 against captured 0010 -> rows 1 and 3 differ
      sweep2(4'b1000, lat);
      chk("c2_latency", lat, 32'd9);
      chk("c2_table", table_out, 4'b0010);
      chk("c2_mism", mismatch_cnt, 3'd2);
      chk("c2_pass", pass, 1'b0);
      tick();

      // Case 3: start held high -> one sweep, then restart after IDLE
      expected  = 4'b0010;
      start     = 1'b1;
      tick();
      seq       = '0;
      done_seen = 0;
      for (int c = 1; c <= 8; c++) begin
         seq = {seq[13:0], dut_in};
         if (done) done_seen++;
         tick();
      end
      chk("c3_dutin_seq", seq, 16'h05AF);
      chk("c3_done_c9", done, 1'b1);
      tick();
      chk("c3_idle_c10", {busy, done}, 2'b00);
      tick();
      chk("c3_restart_c11", {busy, dut_in}, {1'b1, 2'd0});
      chk("c3_no_early_done", done_seen, 32'd0);
      $display("case3 seq=%h restart busy=%0b", seq, busy);
      start = 1'b0;

      // Case 4: reset at cycle 5 of a sweep aborts it
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expected = 4'b0010;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      repeat (4) tick();
      chk("c4_partial_table", table_out, 4'b0010);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("c4_after_rst", {busy, done, dut_in, table_out, mismatch_cnt}, 32'd0);
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) done_seen++;
         tick();
      end
      chk("c4_no_done", done_seen, 32'd0);
      sweep2(4'b0010, lat);
      chk("c4_fresh_latency", lat, 32'd9);
      chk("c4_fresh_pass", {table_out, pass}, {4'b0010, 1'b1});
      tick();

`ifdef FIRST_FAIL_CAPTURE_EN
      // Case 5: 0011 vs 0010 -> only row 0 differs
      sweep2(4'b0011, lat);
      chk("c5_fail_seen", fail_seen, 1'b1);
      chk("c5_first_idx", first_fail_idx, 2'd0);
      chk("c5_mism", mismatch_cnt, 3'd1);
      tick();
      // 1100 vs 0010 -> rows 1,2,3 differ; first stays at row 1
      sweep2(4'b1100, lat);
      chk("c5b_first_idx", {fail_seen, first_fail_idx}, {1'b1, 2'd1});
      chk("c5b_mism", mismatch_cnt, 3'd3);
      tick();
`endif

      // Case 6: 3-input parity with SETTLE=0; expected changed mid-sweep is ignored
      expected3 = 8'b10010110;
      start3    = 1'b1;
      tick();
      start3    = 1'b0;
      expected3 = 8'h00;
      lat = 1;
      while (!done3 && lat < 60) begin
         tick();
         lat++;
      end
      $display("case6 done_cycle=%0d table=%b mism=%0d pass=%0b", lat, table_out3, mismatch_cnt3, pass3);
      chk("c6_latency", lat, 32'd9);
      chk("c6_table", table_out3, 8'h96);
      chk("c6_mism", mismatch_cnt3, 4'd0);
      chk("c6_pass", pass3, 1'b1);
      chk("c6_dutin_hold", dut_in3, 3'd7);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
